// File: rtl/scalu_pkg.sv
// Shared definitions for the scalar ALU issue path: opcode encodings,
// scheduler entry layout and the wakeup helper used on every operand.
package scalu_pkg;

  localparam int TAGW   = 8;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;
  localparam int RD_W   = 6;

  // ALU function in op[3:0]; op[4] selects SUB for ADD and SRA for SRL.
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SLL  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h2;
  localparam logic [3:0] ALU_SLTU = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_OR   = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h7;

  typedef struct packed {
    logic              rdy;
    logic [TAGW-1:0]   tag;
    logic [DATA_W-1:0] value;
  } src_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [TAGW-1:0] robid;
    logic [RD_W-1:0] rd;
    src_t            src1;
    src_t            src2;
  } sched_entry_t;

  // Capture the broadcast value into a waiting operand on a full tag match.
  function automatic src_t wake(input src_t s, input logic wb_valid,
                                input logic [TAGW-1:0] wb_robid,
                                input logic [DATA_W-1:0] wb_result);
    src_t r;
    r = s;
    if (wb_valid && !s.rdy && (s.tag == wb_robid)) begin
      r.rdy   = 1'b1;
      r.value = wb_result;
    end
    return r;
  endfunction

endpackage

// File: rtl/scalu_age_pick.sv
// Age matrix for the scheduler slots plus oldest-requester one-hot select.
// older[i][j] set means slot i was allocated before slot j.
module scalu_age_pick #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] older [DEPTH];

  // A newly allocated slot becomes younger than every currently valid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc[i])      older[i][j] <= 1'b0;
          else if (alloc[j]) older[i][j] <= valid[i];
        end
      end
    end
  end

  // Grant a requester only if no older slot is also requesting.
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic blocked;
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (req[j] && older[j][i]) blocked = 1'b1;
      end
      grant[i] = req[i] && !blocked;
    end
  end

endmodule

// File: rtl/scalu_sched.sv
// Issue scheduler for the single-cycle scalar ALU: buffers dispatched ops,
// wakes operands from the writeback broadcast and issues the oldest ready op.
module scalu_sched
  import scalu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAGW  = scalu_pkg::TAGW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [4:0]      disp_op,
  input  logic [TAGW-1:0] disp_robid,
  input  logic [5:0]      disp_rd,
  input  logic            disp_op1_rdy,
  input  logic            disp_op2_rdy,
  input  logic [TAGW-1:0] disp_op1_tag,
  input  logic [TAGW-1:0] disp_op2_tag,
  input  logic [31:0]     disp_op1,
  input  logic [31:0]     disp_op2,
  input  logic            wb_valid,
  input  logic [TAGW-1:0] wb_robid,
  input  logic [31:0]     wb_result,
  output logic            exers_scalu_issue,
  output logic [4:0]      exers_scalu_op,
  output logic [TAGW-1:0] exers_robid,
  output logic [5:0]      exers_rd,
  output logic [31:0]     exers_op1,
  output logic [31:0]     exers_op2,
  input  logic            scalu_stall,
  input  logic            rob_flush
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] free_oh;
  logic [DEPTH-1:0] alloc;
  logic [DEPTH-1:0] release_oh;
  logic             accept;
  logic             fire;
  sched_entry_t     ent [DEPTH];
  sched_entry_t     new_ent;
  sched_entry_t     sel;

  // Full when every slot is valid; a free in the same cycle is not counted.
  always_comb begin
    disp_ready = ~&valid;
    accept     = disp_valid && disp_ready && !rob_flush;
  end

  // Lowest-index free slot as a one-hot vector.
  always_comb begin
    free_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
    alloc = accept ? free_oh : '0;
  end

  // Incoming entry, with same-cycle writeback capture on its waiting operands.
  always_comb begin
    new_ent.op         = disp_op;
    new_ent.robid      = disp_robid;
    new_ent.rd         = disp_rd;
    new_ent.src1.rdy   = disp_op1_rdy;
    new_ent.src1.tag   = disp_op1_tag;
    new_ent.src1.value = disp_op1;
    new_ent.src2.rdy   = disp_op2_rdy;
    new_ent.src2.tag   = disp_op2_tag;
    new_ent.src2.value = disp_op2;
    new_ent.src1       = wake(new_ent.src1, wb_valid, wb_robid, wb_result);
    new_ent.src2       = wake(new_ent.src2, wb_valid, wb_robid, wb_result);
  end

  // Readiness comes from registered state only, so wakeup never bypasses into select.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid[i] && ent[i].src1.rdy && ent[i].src2.rdy;
    end
  end

  scalu_age_pick #(.DEPTH(DEPTH)) u_age_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .alloc (alloc),
    .valid (valid),
    .req   (ready),
    .grant (grant)
  );

  // Issue mux: OR of the granted slot, all zero when nothing is ready.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel = sel | ent[i];
    end
    exers_scalu_issue = (|ready) && !rob_flush;
    exers_scalu_op    = sel.op;
    exers_robid       = sel.robid;
    exers_rd          = sel.rd;
    exers_op1         = sel.src1.value;
    exers_op2         = sel.src2.value;
    fire              = exers_scalu_issue && !scalu_stall;
    release_oh        = fire ? grant : '0;
  end

  // Slot occupancy: flush clears everything, otherwise free the issued slot and fill the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         valid <= '0;
    else if (rob_flush) valid <= '0;
    else                valid <= (valid & ~release_oh) | alloc;
  end

  // Entry payload: written on allocation, otherwise waiting operands snoop writeback.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc[i]) begin
        ent[i] <= new_ent;
      end else begin
        ent[i].src1 <= wake(ent[i].src1, wb_valid, wb_robid, wb_result);
        ent[i].src2 <= wake(ent[i].src2, wb_valid, wb_robid, wb_result);
      end
    end
  end

endmodule

// File: tb/tb_scalu_sched.sv
// Bench for scalu_sched: directed scenarios followed by random traffic,
// checked against an age-ordered queue model of the scheduler.
module tb_scalu_sched;

  localparam int DEPTH = 4;
  localparam int TAGW  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            disp_valid;
  logic            disp_ready;
  logic [4:0]      disp_op;
  logic [TAGW-1:0] disp_robid;
  logic [5:0]      disp_rd;
  logic            disp_op1_rdy, disp_op2_rdy;
  logic [TAGW-1:0] disp_op1_tag, disp_op2_tag;
  logic [31:0]     disp_op1, disp_op2;
  logic            wb_valid;
  logic [TAGW-1:0] wb_robid;
  logic [31:0]     wb_result;
  logic            exers_scalu_issue;
  logic [4:0]      exers_scalu_op;
  logic [TAGW-1:0] exers_robid;
  logic [5:0]      exers_rd;
  logic [31:0]     exers_op1, exers_op2;
  logic            scalu_stall;
  logic            rob_flush;

  int checks = 0;
  int errors = 0;

  scalu_sched #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_robid(disp_robid), .disp_rd(disp_rd),
    .disp_op1_rdy(disp_op1_rdy), .disp_op2_rdy(disp_op2_rdy),
    .disp_op1_tag(disp_op1_tag), .disp_op2_tag(disp_op2_tag),
    .disp_op1(disp_op1), .disp_op2(disp_op2),
    .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_result(wb_result),
    .exers_scalu_issue(exers_scalu_issue), .exers_scalu_op(exers_scalu_op),
    .exers_robid(exers_robid), .exers_rd(exers_rd),
    .exers_op1(exers_op1), .exers_op2(exers_op2),
    .scalu_stall(scalu_stall), .rob_flush(rob_flush)
  );

  always #5 clk = ~clk;

  // Model: queue in dispatch order, so index 0 is always the oldest op.
  typedef struct {
    logic [4:0]  op;
    logic [7:0]  robid;
    logic [5:0]  rd;
    logic        r1;
    logic [7:0]  t1;
    logic [31:0] v1;
    logic        r2;
    logic [7:0]  t2;
    logic [31:0] v2;
  } ment_t;

  ment_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_sel();
    for (int i = 0; i < q.size(); i++) if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  function automatic bit hit(input logic r, input logic [7:0] t);
    return !r && wb_valid && (t == wb_robid);
  endfunction

  task automatic model_edge();
    int    s;
    bit    fire, acc;
    ment_t n;
    s    = model_sel();
    fire = (s >= 0) && !rob_flush && !scalu_stall;
    acc  = disp_valid && (q.size() < DEPTH) && !rob_flush;
    if (rob_flush) begin
      q.delete();
      return;
    end
    n.op = disp_op; n.robid = disp_robid; n.rd = disp_rd;
    n.r1 = disp_op1_rdy; n.t1 = disp_op1_tag; n.v1 = disp_op1;
    n.r2 = disp_op2_rdy; n.t2 = disp_op2_tag; n.v2 = disp_op2;
    if (hit(n.r1, n.t1)) begin n.r1 = 1'b1; n.v1 = wb_result; end
    if (hit(n.r2, n.t2)) begin n.r2 = 1'b1; n.v2 = wb_result; end
    for (int i = 0; i < q.size(); i++) begin
      if (hit(q[i].r1, q[i].t1)) begin q[i].r1 = 1'b1; q[i].v1 = wb_result; end
      if (hit(q[i].r2, q[i].t2)) begin q[i].r2 = 1'b1; q[i].v2 = wb_result; end
    end
    if (fire) q.delete(s);
    if (acc)  q.push_back(n);
  endtask

  // Compare outputs for the current inputs, then advance DUT and model by one edge.
  task automatic step();
    int s;
    #1;
    s = model_sel();
    chk("disp_ready", disp_ready, q.size() < DEPTH);
    chk("issue", exers_scalu_issue, (s >= 0) && !rob_flush);
    if (s >= 0) begin
      chk("op",    exers_scalu_op, q[s].op);
      chk("robid", exers_robid,    q[s].robid);
      chk("rd",    exers_rd,       q[s].rd);
      chk("op1",   exers_op1,      q[s].v1);
      chk("op2",   exers_op2,      q[s].v2);
    end else begin
      chk("op_zero",    exers_scalu_op, 0);
      chk("robid_zero", exers_robid,    0);
      chk("rd_zero",    exers_rd,       0);
      chk("op1_zero",   exers_op1,      0);
      chk("op2_zero",   exers_op2,      0);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 0; disp_op = 0; disp_robid = 0; disp_rd = 0;
    disp_op1_rdy = 0; disp_op2_rdy = 0; disp_op1_tag = 0; disp_op2_tag = 0;
    disp_op1 = 0; disp_op2 = 0;
    wb_valid = 0; wb_robid = 0; wb_result = 0;
    scalu_stall = 0; rob_flush = 0;
  endtask

  task automatic dsp(input logic [4:0] op, input logic [7:0] robid, input logic [5:0] rd,
                     input logic r1, input logic [7:0] t1, input logic [31:0] v1,
                     input logic r2, input logic [7:0] t2, input logic [31:0] v2);
    disp_valid = 1; disp_op = op; disp_robid = robid; disp_rd = rd;
    disp_op1_rdy = r1; disp_op1_tag = t1; disp_op1 = v1;
    disp_op2_rdy = r2; disp_op2_tag = t2; disp_op2 = v2;
  endtask

  task automatic wb(input logic [7:0] id, input logic [31:0] val);
    wb_valid = 1; wb_robid = id; wb_result = val;
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_issue", exers_scalu_issue, 0);
    chk("rst_robid", exers_robid, 0);
    chk("rst_op1", exers_op1, 0);
    rst_n = 1;
    step();

    // Ready ADD issues the cycle after dispatch.
    dsp(5'h00, 8'd3, 6'd1, 1, 0, 32'd5, 1, 0, 32'd7);
    step();
    idle();
    #1;
    chk("t1_issue", exers_scalu_issue, 1);
    chk("t1_robid", exers_robid, 3);
    chk("t1_op1", exers_op1, 5);
    chk("t1_op2", exers_op2, 7);
    step();
    #1;
    chk("t1_empty_issue", exers_scalu_issue, 0);
    chk("t1_empty_ready", disp_ready, 1);
    step();

    // Waiting operand woken by a later writeback.
    dsp(5'h01, 8'd4, 6'd2, 1, 0, 32'h11, 0, 8'd9, 0);
    step();
    idle();
    step();
    wb(8'd9, 32'h55);
    step();
    idle();
    #1;
    chk("t2_issue", exers_scalu_issue, 1);
    chk("t2_op2", exers_op2, 32'h55);
    step();

    // Same-cycle writeback captured at allocation.
    dsp(5'h04, 8'h20, 6'd3, 0, 8'h12, 0, 1, 0, 32'h9);
    wb(8'h12, 32'habc);
    step();
    idle();
    #1;
    chk("t5_op1", exers_op1, 32'habc);
    step();

    // Stall holds the selected entry.
    dsp(5'h07, 8'h30, 6'd4, 1, 0, 32'h1234, 1, 0, 32'h5678);
    step();
    idle();
    scalu_stall = 1;
    repeat (3) step();
    scalu_stall = 0;
    step();
    step();

    // Fill with waiting ops, wake two, oldest goes first.
    dsp(5'h00, 8'd10, 6'd10, 0, 8'd1, 0, 1, 0, 32'ha0); step();
    dsp(5'h00, 8'd11, 6'd11, 0, 8'd2, 0, 1, 0, 32'ha1); step();
    dsp(5'h00, 8'd12, 6'd12, 0, 8'd3, 0, 1, 0, 32'ha2); step();
    dsp(5'h00, 8'd13, 6'd13, 0, 8'd4, 0, 1, 0, 32'ha3); step();
    idle();
    #1;
    chk("t3_full", disp_ready, 0);
    scalu_stall = 1;
    wb(8'd2, 32'hb2); step();
    wb(8'd1, 32'hb1); step();
    wb_valid = 0;
    #1;
    chk("t3_oldest", exers_robid, 10);
    step();
    scalu_stall = 0;
    step();
    step();

    // Flush with two ready entries and a concurrent dispatch.
    dsp(5'h02, 8'h40, 6'd5, 1, 0, 32'd1, 1, 0, 32'd2);
    step();
    dsp(5'h03, 8'h41, 6'd6, 1, 0, 32'd3, 1, 0, 32'd4);
    scalu_stall = 1;
    step();
    dsp(5'h06, 8'h42, 6'd7, 1, 0, 32'd5, 1, 0, 32'd6);
    rob_flush = 1;
    #1;
    chk("t6_flush_issue", exers_scalu_issue, 0);
    step();
    idle();
    #1;
    chk("t6_after_ready", disp_ready, 1);
    chk("t6_after_issue", exers_scalu_issue, 0);
    step();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      disp_valid   = 1'($urandom_range(0, 1));
      disp_op      = 5'($urandom);
      disp_robid   = 8'($urandom_range(0, 15));
      disp_rd      = 6'($urandom);
      disp_op1_rdy = 1'($urandom_range(0, 1));
      disp_op2_rdy = 1'($urandom_range(0, 1));
      disp_op1_tag = 8'($urandom_range(0, 7));
      disp_op2_tag = 8'($urandom_range(0, 7));
      disp_op1     = $urandom;
      disp_op2     = $urandom;
      wb_valid     = 1'($urandom_range(0, 1));
      wb_robid     = 8'($urandom_range(0, 7));
      wb_result    = $urandom;
      scalu_stall  = ($urandom_range(0, 3) == 0);
      rob_flush    = ($urandom_range(0, 40) == 0);
      step();
    end

    // Asynchronous reset in the middle of traffic, then resume.
    idle();
    dsp(5'h00, 8'h50, 6'd8, 1, 0, 32'd8, 0, 8'd7, 0);
    step();
    dsp(5'h00, 8'h51, 6'd9, 1, 0, 32'd9, 1, 0, 32'd10);
    step();
    idle();
    rst_n = 0;
    #1;
    chk("mid_rst_ready", disp_ready, 1);
    chk("mid_rst_issue", exers_scalu_issue, 0);
    chk("mid_rst_robid", exers_robid, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    dsp(5'h05, 8'h52, 6'd11, 1, 0, 32'hc0, 1, 0, 32'hc1);
    step();
    idle();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
